// File: rtl/blackparrot_fpga_host_pkg.sv
// Types shared by the BlackParrot FPGA host AXIL read/write demuxes.
package blackparrot_fpga_host_pkg;

    typedef enum logic [0:0] {
        e_ready = 1'b0,
        e_resp  = 1'b1
    } state_e;

endpackage

// File: rtl/bsg_axi_pkg.sv
// AXI response encodings shared by the host-side AXI/AXIL adapters.
package bsg_axi_pkg;

    typedef enum logic [1:0] {
        e_axi_resp_okay   = 2'b00,
        e_axi_resp_exokay = 2'b01,
        e_axi_resp_slverr = 2'b10,
        e_axi_resp_decerr = 2'b11
    } axi_resp_type_e;

endpackage

// File: rtl/blackparrot_fpga_host_addr_decode.sv
// Masked base-address decoder: lowest matching channel wins; offset strips the matched bits.
module blackparrot_fpga_host_addr_decode #(
    parameter int els_p        = 1,
    parameter int addr_width_p = 64
) (
    input  logic [addr_width_p-1:0]            addr_i,
    input  logic [els_p-1:0][addr_width_p-1:0] base_i,
    input  logic [els_p-1:0][addr_width_p-1:0] mask_i,
    output logic                               match_v_o,
    output logic [els_p-1:0]                   sel_o,
    output logic [addr_width_p-1:0]            offset_o
);

    // Priority scan from channel 0 upward.
    always_comb begin
        match_v_o = 1'b0;
        sel_o     = '0;
        offset_o  = '0;
        for (int i = 0; i < els_p; i++) begin
            if (!match_v_o && ((addr_i & mask_i[i]) == (base_i[i] & mask_i[i]))) begin
                match_v_o = 1'b1;
                sel_o[i]  = 1'b1;
                offset_o  = addr_i & ~mask_i[i];
            end else begin
                sel_o[i]  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry ready/valid FIFO; the consumer pops with yumi_i (only when v_o is high).
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_r [2];
    logic               head_r;
    logic               tail_r;
    logic [1:0]         cnt_r;
    logic               enq_s;

    assign ready_o = (cnt_r != 2'd2);
    assign v_o     = (cnt_r != 2'd0);
    assign data_o  = mem_r[head_r];
    assign enq_s   = v_i & ready_o;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_r <= 1'b0;
            tail_r <= 1'b0;
            cnt_r  <= 2'd0;
        end else begin
            head_r <= yumi_i ? ~head_r : head_r;
            tail_r <= enq_s ? ~tail_r : tail_r;
            cnt_r  <= cnt_r + {1'b0, enq_s} - {1'b0, yumi_i};
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            mem_r[tail_r] <= data_i;
        end else begin
            mem_r[tail_r] <= mem_r[tail_r];
        end
    end

endmodule

// File: rtl/blackparrot_fpga_host_axil_write_demux.sv
// AXI4-Lite write slave steering each write to one of CSR_ELS_P ready/valid channels,
// with masked decode, configurable error responses and an optional stall timeout.
module blackparrot_fpga_host_axil_write_demux
    import bsg_axi_pkg::*;
    import blackparrot_fpga_host_pkg::*;
#(
    parameter int S_AXIL_ADDR_WIDTH = 64,
    parameter int S_AXIL_DATA_WIDTH = 32,
    parameter int CSR_ELS_P         = 1,
    parameter logic [CSR_ELS_P-1:0][S_AXIL_ADDR_WIDTH-1:0] csr_addr_p = '0,
    parameter logic [CSR_ELS_P-1:0][S_AXIL_ADDR_WIDTH-1:0] csr_mask_p = '1,
    parameter int timeout_p         = 0,
    parameter int decerr_p          = 1,
    parameter int strict_strb_p     = 0,
    parameter int err_cnt_width_p   = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]                     s_axil_awprot,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    input  logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [S_AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready,
    output logic [1:0]                     s_axil_bresp,
    output logic [CSR_ELS_P-1:0]           fifo_v_o,
    input  logic [CSR_ELS_P-1:0]           fifo_ready_and_i,
    output logic [S_AXIL_DATA_WIDTH-1:0]   fifo_data_o,
    output logic [S_AXIL_ADDR_WIDTH-1:0]   fifo_addr_o,
    output logic                           err_v_o,
    output logic [err_cnt_width_p-1:0]     err_count_o
);

    localparam int STRB_W  = S_AXIL_DATA_WIDTH / 8;
    localparam int STALL_W = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;

    logic                         aw_ready_s, aw_v_s, w_ready_s, w_v_s, pop_s;
    logic [S_AXIL_ADDR_WIDTH-1:0] aw_addr_s, offset_s;
    logic [S_AXIL_DATA_WIDTH-1:0] w_data_s;
    logic [STRB_W-1:0]            w_strb_s;
    logic                         match_s, strb_bad_s, latch_s, err_n_s, unused_s;
    logic [CSR_ELS_P-1:0]         sel_s;
    state_e                       state_r, state_n;
    axi_resp_type_e               bresp_r, resp_n_s;
    logic [STALL_W-1:0]           stall_r, stall_n, stall_inc_s;
    logic                         err_v_r;
    logic [err_cnt_width_p-1:0]   err_cnt_r;

    assign unused_s = ^s_axil_awprot;

    bsg_two_fifo #(.width_p(S_AXIL_ADDR_WIDTH)) aw_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ready_o (aw_ready_s),
        .data_i  (s_axil_awaddr),
        .v_i     (s_axil_awvalid),
        .v_o     (aw_v_s),
        .data_o  (aw_addr_s),
        .yumi_i  (pop_s)
    );

    bsg_two_fifo #(.width_p(S_AXIL_DATA_WIDTH + STRB_W)) w_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ready_o (w_ready_s),
        .data_i  ({s_axil_wstrb, s_axil_wdata}),
        .v_i     (s_axil_wvalid),
        .v_o     (w_v_s),
        .data_o  ({w_strb_s, w_data_s}),
        .yumi_i  (pop_s)
    );

    blackparrot_fpga_host_addr_decode #(
        .els_p        (CSR_ELS_P),
        .addr_width_p (S_AXIL_ADDR_WIDTH)
    ) decode (
        .addr_i    (aw_addr_s),
        .base_i    (csr_addr_p),
        .mask_i    (csr_mask_p),
        .match_v_o (match_s),
        .sel_o     (sel_s),
        .offset_o  (offset_s)
    );

    // The buffers come out of reset empty but must not look ready while reset is held.
    assign s_axil_awready = aw_ready_s & ~reset_i;
    assign s_axil_wready  = w_ready_s & ~reset_i;
    assign s_axil_bvalid  = (state_r == e_resp);
    assign s_axil_bresp   = bresp_r;
    assign fifo_data_o    = w_data_s;
    assign fifo_addr_o    = offset_s;
    assign err_v_o        = err_v_r;
    assign err_count_o    = err_cnt_r;
    assign strb_bad_s     = (strict_strb_p != 0) && !(&w_strb_s);
    assign stall_inc_s    = stall_r + STALL_W'(1);

    // Transaction FSM: decode, forward, time out, then hold the response.
    always_comb begin
        state_n  = state_r;
        stall_n  = stall_r;
        pop_s    = 1'b0;
        latch_s  = 1'b0;
        err_n_s  = 1'b0;
        resp_n_s = e_axi_resp_okay;
        fifo_v_o = '0;
        case (state_r)
            e_ready: begin
                if (aw_v_s && w_v_s) begin
                    if (strb_bad_s) begin
                        latch_s  = 1'b1;
                        err_n_s  = 1'b1;
                        resp_n_s = e_axi_resp_slverr;
                    end else if (!match_s) begin
                        latch_s  = 1'b1;
                        err_n_s  = (decerr_p != 0);
                        resp_n_s = (decerr_p != 0) ? e_axi_resp_decerr : e_axi_resp_okay;
                    end else begin
                        fifo_v_o = sel_s;
                        if (|(sel_s & fifo_ready_and_i)) begin
                            latch_s  = 1'b1;
                        end else if ((timeout_p != 0) && (stall_inc_s == STALL_W'(timeout_p))) begin
                            latch_s  = 1'b1;
                            err_n_s  = 1'b1;
                            resp_n_s = e_axi_resp_slverr;
                        end else begin
                            stall_n  = stall_inc_s;
                        end
                    end
                    pop_s   = latch_s;
                    state_n = latch_s ? e_resp : e_ready;
                end else begin
                    state_n = e_ready;
                end
            end
            e_resp: begin
                if (s_axil_bready) begin
                    state_n = e_ready;
                    stall_n = '0;
                end else begin
                    state_n = e_resp;
                end
            end
            default: begin
                state_n = e_ready;
                stall_n = '0;
            end
        endcase
    end

    // State, latched response and saturating error counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= e_ready;
            stall_r   <= '0;
            bresp_r   <= e_axi_resp_okay;
            err_v_r   <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            state_r <= state_n;
            stall_r <= stall_n;
            err_v_r <= err_n_s;
            bresp_r <= latch_s ? resp_n_s : bresp_r;
            if (err_n_s && !(&err_cnt_r)) begin
                err_cnt_r <= err_cnt_r + err_cnt_width_p'(1);
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_blackparrot_fpga_host_axil_write_demux.sv
// Bench for the AXIL write demux: a 3-channel exact-match instance (A) and a
// 1-channel masked instance (B) share one stimulus port selected by dsel.
module tb_blackparrot_fpga_host_axil_write_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, dsel, awvalid, wvalid, bready;
    logic [63:0] awaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  fready;

    logic        a_awready, a_wready, a_bvalid, a_err_v;
    logic [1:0]  a_bresp;
    logic [2:0]  a_fifo_v;
    logic [31:0] a_fdata;
    logic [63:0] a_faddr;
    logic [15:0] a_err_cnt;
    logic        b_awready, b_wready, b_bvalid, b_err_v;
    logic [1:0]  b_bresp;
    logic [0:0]  b_fifo_v;
    logic [31:0] b_fdata;
    logic [63:0] b_faddr;
    logic [15:0] b_err_cnt;

    blackparrot_fpga_host_axil_write_demux #(
        .CSR_ELS_P     (3),
        .csr_addr_p    ({64'h300, 64'h200, 64'h100}),
        .csr_mask_p    ({3{64'hFFFF_FFFF_FFFF_FFFF}}),
        .timeout_p     (4),
        .decerr_p      (1),
        .strict_strb_p (1)
    ) dut_a (
        .clk_i(clk), .reset_i(reset),
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid & ~dsel),
        .s_axil_awready(a_awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid & ~dsel),
        .s_axil_wready(a_wready),
        .s_axil_bvalid(a_bvalid), .s_axil_bready(bready & ~dsel), .s_axil_bresp(a_bresp),
        .fifo_v_o(a_fifo_v), .fifo_ready_and_i(fready), .fifo_data_o(a_fdata),
        .fifo_addr_o(a_faddr), .err_v_o(a_err_v), .err_count_o(a_err_cnt)
    );

    blackparrot_fpga_host_axil_write_demux #(
        .CSR_ELS_P     (1),
        .csr_addr_p    (64'h1000),
        .csr_mask_p    (64'hFFFF_FFFF_FFFF_FF00),
        .timeout_p     (0),
        .decerr_p      (0),
        .strict_strb_p (0)
    ) dut_b (
        .clk_i(clk), .reset_i(reset),
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid & dsel),
        .s_axil_awready(b_awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid & dsel),
        .s_axil_wready(b_wready),
        .s_axil_bvalid(b_bvalid), .s_axil_bready(bready & dsel), .s_axil_bresp(b_bresp),
        .fifo_v_o(b_fifo_v), .fifo_ready_and_i(fready[0:0]), .fifo_data_o(b_fdata),
        .fifo_addr_o(b_faddr), .err_v_o(b_err_v), .err_count_o(b_err_cnt)
    );

    wire        awready = dsel ? b_awready : a_awready;
    wire        wready  = dsel ? b_wready  : a_wready;
    wire        bvalid  = dsel ? b_bvalid  : a_bvalid;
    wire [1:0]  bresp   = dsel ? b_bresp   : a_bresp;
    wire [2:0]  fifo_v  = dsel ? {2'b00, b_fifo_v} : a_fifo_v;
    wire [31:0] fdata   = dsel ? b_fdata   : a_fdata;
    wire [63:0] faddr   = dsel ? b_faddr   : a_faddr;
    wire        err_v   = dsel ? b_err_v   : a_err_v;
    wire [15:0] err_cnt = dsel ? b_err_cnt : a_err_cnt;

    typedef struct {
        logic        d;
        logic [63:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  rdy;
        logic [2:0]  ev;
        logic [63:0] eaddr;
        logic [1:0]  eresp;
        logic        eerr;
        int          elat;
    } vec_t;

    typedef struct {
        logic [1:0] resp;
        logic       err;
    } exp_t;

    vec_t        vecs[11];
    exp_t        sb_q[$];
    logic [31:0] data_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          model_a = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare the response now on the B channel against the scoreboard head.
    task automatic check_b(input string tag);
        exp_t e;
        int   exp_cnt;
        exp_cnt = dsel ? 0 : model_a;
        if (sb_q.size() == 0) begin
            chk({tag, "_unexpected_bvalid"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_bresp"}, bresp, e.resp);
            chk({tag, "_err_v"}, err_v, e.err);
            chk({tag, "_err_count"}, err_cnt, exp_cnt);
        end
    endtask

    // Present AW and W together; returns #1 after the edge that accepted the later one.
    task automatic send(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s);
        logic sa, sw;
        int   guard;
        guard = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while ((awvalid || wvalid) && guard < 50) begin
            @(negedge clk);
            sa = awready;
            sw = wready;
            @(posedge clk); #1;
            if (sa) awvalid = 1'b0;
            if (sw) wvalid = 1'b0;
            guard++;
        end
        if (awvalid || wvalid) begin
            chk("send_accept_timeout", 64'd0, 64'd1);
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        bit   got;
        v = vecs[idx];
        got = 1'b0;
        dsel = v.d;
        fready = v.rdy;
        if (v.eerr && !v.d) model_a++;
        sb_q.push_back('{v.eresp, v.eerr});
        send(v.addr, v.data, v.strb);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bvalid) begin
                got = 1'b1;
                check_b($sformatf("vec%0d", idx));
                chk($sformatf("vec%0d_latency", idx), c, v.elat);
            end else begin
                chk($sformatf("vec%0d_fifo_v", idx), fifo_v, v.ev);
                if (v.ev != 3'b000) begin
                    chk($sformatf("vec%0d_data", idx), fdata, v.data);
                    chk($sformatf("vec%0d_addr", idx), faddr, v.eaddr);
                end
            end
        end
        if (!got) chk($sformatf("vec%0d_bvalid_timeout", idx), 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        logic sa, sw;
        int   k_aw, k_w, n_resp;
        logic [31:0] bp_data[3];
        bit   got;

        //        d     addr      data          strb  rdy     ev      eaddr   resp   err  lat
        vecs[0]  = '{1'b0, 64'h200,  32'hDEADBEEF, 4'hF, 3'b111, 3'b010, 64'h0,  2'b00, 1'b0, 1};
        vecs[1]  = '{1'b0, 64'h100,  32'h12345678, 4'hF, 3'b001, 3'b001, 64'h0,  2'b00, 1'b0, 1};
        vecs[2]  = '{1'b0, 64'h300,  32'hA5A5_0F0F, 4'hF, 3'b100, 3'b100, 64'h0, 2'b00, 1'b0, 1};
        vecs[3]  = '{1'b0, 64'h999,  32'h0000_0001, 4'hF, 3'b111, 3'b000, 64'h0, 2'b11, 1'b1, 1};
        vecs[4]  = '{1'b0, 64'h300,  32'hCAFE_F00D, 4'h3, 3'b111, 3'b000, 64'h0, 2'b10, 1'b1, 1};
        vecs[5]  = '{1'b0, 64'h200,  32'h5555_AAAA, 4'hF, 3'b101, 3'b010, 64'h0, 2'b10, 1'b1, 4};
        vecs[6]  = '{1'b0, 64'h100,  32'h0BAD_BEEF, 4'hF, 3'b111, 3'b001, 64'h0, 2'b00, 1'b0, 1};
        vecs[7]  = '{1'b0, 64'h201,  32'h1111_2222, 4'hF, 3'b111, 3'b000, 64'h0, 2'b11, 1'b1, 1};
        vecs[8]  = '{1'b1, 64'h1034, 32'h7777_8888, 4'hF, 3'b001, 3'b001, 64'h34, 2'b00, 1'b0, 1};
        vecs[9]  = '{1'b1, 64'h999,  32'h9999_0000, 4'hF, 3'b001, 3'b000, 64'h0, 2'b00, 1'b0, 1};
        vecs[10] = '{1'b1, 64'h10FF, 32'h0102_0304, 4'h1, 3'b001, 3'b001, 64'hFF, 2'b00, 1'b0, 1};

        reset = 1'b1; dsel = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        awaddr = 64'h0; wdata = 32'h0; wstrb = 4'h0; fready = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready, 64'd0);
        chk("rst_wready", wready, 64'd0);
        chk("rst_bvalid", bvalid, 64'd0);
        chk("rst_fifo_v", fifo_v, 64'd0);
        chk("rst_err_v", err_v, 64'd0);
        chk("rst_err_count", err_cnt, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_awready", awready, 64'd1);
        chk("post_rst_wready", wready, 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_vec(i);

        // W arrives five cycles ahead of AW on the masked instance.
        dsel = 1'b1; fready = 3'b001;
        wdata = 32'hFEED_0034; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        chk("early_w_wready", wready, 64'd1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("early_w_no_valid", fifo_v, 64'd0);
        end
        @(posedge clk); #1;
        sb_q.push_back('{2'b00, 1'b0});
        awaddr = 64'h1034; awvalid = 1'b1;
        @(negedge clk);
        chk("late_aw_awready", awready, 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        chk("late_aw_fifo_v", fifo_v, 64'd1);
        chk("late_aw_addr", faddr, 64'h34);
        chk("late_aw_data", fdata, 64'hFEED_0034);
        @(negedge clk);
        chk("late_aw_bvalid", bvalid, 64'd1);
        if (bvalid) check_b("late_aw");
        @(posedge clk); #1;

        // Three writes with bready low: two stay buffered, then all drain in order.
        dsel = 1'b0; fready = 3'b001; bready = 1'b0;
        bp_data[0] = 32'hB0B0_0000; bp_data[1] = 32'hB1B1_1111; bp_data[2] = 32'hB2B2_2222;
        for (int i = 0; i < 3; i++) begin
            data_q.push_back(bp_data[i]);
            sb_q.push_back('{2'b00, 1'b0});
        end
        k_aw = 0; k_w = 0;
        awaddr = 64'h100; wdata = bp_data[0]; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            sa = awready;
            sw = wready;
            if (bvalid) chk("bp_no_valid_in_resp", fifo_v, 64'd0);
            if (fifo_v[0] && data_q.size() > 0) chk("bp_data_order", fdata, data_q.pop_front());
            @(posedge clk); #1;
            if (sa && awvalid) begin
                k_aw++;
                if (k_aw == 3) awvalid = 1'b0;
            end
            if (sw && wvalid) begin
                k_w++;
                if (k_w == 3) wvalid = 1'b0;
                else wdata = bp_data[k_w];
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("bp_aw_accepted", k_aw, 64'd3);
        chk("bp_awready_low", awready, 64'd0);
        chk("bp_wready_low", wready, 64'd0);
        chk("bp_bvalid_held", bvalid, 64'd1);
        @(posedge clk); #1;
        bready = 1'b1;
        n_resp = 0;
        for (int c = 0; c < 30 && n_resp < 3; c++) begin
            @(negedge clk);
            if (fifo_v[0] && data_q.size() > 0) chk("bp_data_order", fdata, data_q.pop_front());
            if (bvalid) begin
                check_b($sformatf("bp_resp%0d", n_resp));
                n_resp++;
            end
        end
        chk("bp_resp_count", n_resp, 64'd3);
        chk("bp_data_drained", data_q.size(), 64'd0);
        @(posedge clk); #1;

        // Reset while a DECERR response is pending.
        bready = 1'b0;
        model_a++;
        sb_q.push_back('{2'b11, 1'b1});
        send(64'h999, 32'h0, 4'hF);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (bvalid) begin
                got = 1'b1;
                check_b("pre_reset");
            end
        end
        if (!got) chk("pre_reset_bvalid_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_awready", awready, 64'd0);
        @(negedge clk);
        chk("mid_rst_bvalid", bvalid, 64'd0);
        chk("mid_rst_err_count", err_cnt, 64'd0);
        chk("mid_rst_fifo_v", fifo_v, 64'd0);
        model_a = 0;
        sb_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        bready = 1'b1;
        @(negedge clk);
        chk("after_rst_awready", awready, 64'd1);
        @(posedge clk); #1;
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
